// File: rtl/uart_mem_bridge.sv
// UART command engine: parses CMD/ADDR/LEN/payload frames, reads or writes memory words,
// and answers with checksum + ACK, NAK on inter-byte timeout, or a warmboot request.
module uart_mem_bridge #(
    parameter int DATA_BYTES     = 2,
    parameter int ADDR_WIDTH     = 14,
    parameter int SEL_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    rx_valid_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    tx_busy_i,
    output logic                    tx_en_o,
    output logic [7:0]              tx_data_o,
    output logic [SEL_BITS-1:0]     mem_sel_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [8*DATA_BYTES-1:0] mem_wdata_o,
    output logic                    mem_we_o,
    output logic                    mem_re_o,
    input  logic [8*DATA_BYTES-1:0] mem_rdata_i,
    output logic                    warmboot_o,
    output logic [1:0]              warmboot_select_o,
    output logic                    timeout_err_o,
    output logic                    active_o
);

    localparam int W          = 8 * DATA_BYTES;
    localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RX_ADDR, S_RX_LEN, S_RD_REQ, S_RD_CAP, S_TX_BYTE,
        S_TX_WAIT, S_RX_DATA, S_WR_MEM, S_TX_SUM, S_TX_ACK, S_TX_NAK
    } state_t;

    state_t                state_q, state_d;
    logic                  rxv_q;
    logic                  is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [8:0]            off_q, off_d;
    logic [W-1:0]          sh_q, sh_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  tx_en_q, tx_en_d;
    logic                  tx_guard_q;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [SEL_BITS-1:0]   sel_q, sel_d;
    logic                  wb_pend_q, wb_pend_d;
    logic                  wb_q, wb_d;
    logic [1:0]            wbs_q, wbs_d;
    logic                  tout_q, tout_d;

    logic byte_acc, can_send, last_word, rx_state, expire;

    assign byte_acc  = rx_valid_i & ~rxv_q;
    // tx_busy only rises the cycle after tx_en, so the strobe and the cycle after it also block.
    assign can_send  = ~tx_busy_i & ~tx_en_q & ~tx_guard_q;
    assign last_word = (off_q == {1'b0, len_q});
    assign rx_state  = (state_q == S_RX_ADDR) || (state_q == S_RX_LEN) || (state_q == S_RX_DATA);
    assign expire    = rx_state && !byte_acc && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        len_d     = len_q;
        off_d     = off_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        sel_d     = sel_q;
        wb_pend_d = 1'b0;
        wb_d      = wb_q | wb_pend_q;
        wbs_d     = wbs_q;
        tout_d    = tout_q;
        timer_d   = (rx_state && !byte_acc) ? timer_q + TW'(1) : '0;

        case (state_q)
            S_IDLE: begin
                if (byte_acc) begin
                    tout_d = 1'b0;
                    case (rx_data_i[7:6])
                        2'b00, 2'b01: begin
                            is_wr_d = rx_data_i[6];
                            sel_d   = rx_data_i[SEL_BITS-1:0];
                            cnt_d   = '0;
                            state_d = S_RX_ADDR;
                        end
                        2'b10: begin
                            wbs_d     = rx_data_i[1:0];
                            wb_pend_d = 1'b1;
                        end
                        default: state_d = S_TX_ACK;
                    endcase
                end
            end
            S_RX_ADDR: begin
                if (byte_acc) begin
                    // Shifting MSB-first into a register of exactly ADDR_WIDTH drops surplus high bits.
                    addr_d = ADDR_WIDTH'({addr_q, rx_data_i});
                    if (cnt_q == 3'(ADDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_RX_LEN;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (expire) begin
                    tout_d  = 1'b1;
                    state_d = S_TX_NAK;
                end
            end
            S_RX_LEN: begin
                if (byte_acc) begin
                    len_d   = rx_data_i;
                    off_d   = '0;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = is_wr_q ? S_RX_DATA : S_RD_REQ;
                end else if (expire) begin
                    tout_d  = 1'b1;
                    state_d = S_TX_NAK;
                end
            end
            S_RD_REQ: state_d = S_RD_CAP;
            S_RD_CAP: begin
                sh_d    = mem_rdata_i;
                cnt_d   = '0;
                state_d = S_TX_BYTE;
            end
            S_TX_BYTE: begin
                if (can_send) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = sh_q[W-1 -: 8];
                    sum_d     = sum_q + sh_q[W-1 -: 8];
                    sh_d      = sh_q << 8;
                    state_d   = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                if (can_send) begin
                    if (cnt_q != 3'(DATA_BYTES - 1)) begin
                        cnt_d   = cnt_q + 3'd1;
                        state_d = S_TX_BYTE;
                    end else if (last_word) begin
                        state_d = S_TX_SUM;
                    end else begin
                        off_d   = off_q + 9'd1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RX_DATA: begin
                if (byte_acc) begin
                    sh_d  = W'({sh_q, rx_data_i});
                    sum_d = sum_q + rx_data_i;
                    if (cnt_q == 3'(DATA_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_WR_MEM;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (expire) begin
                    tout_d  = 1'b1;
                    state_d = S_TX_NAK;
                end
            end
            S_WR_MEM: begin
                if (last_word) begin
                    state_d = S_TX_SUM;
                end else begin
                    off_d   = off_q + 9'd1;
                    state_d = S_RX_DATA;
                end
            end
            S_TX_SUM: begin
                if (can_send) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = sum_q;
                    state_d   = S_TX_ACK;
                end
            end
            S_TX_ACK: begin
                if (can_send) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = 8'h06;
                    state_d   = S_IDLE;
                end
            end
            S_TX_NAK: begin
                if (can_send) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = 8'h15;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            rxv_q      <= 1'b0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            off_q      <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            timer_q    <= '0;
            tx_en_q    <= 1'b0;
            tx_guard_q <= 1'b0;
            tx_data_q  <= '0;
            sel_q      <= '0;
            wb_pend_q  <= 1'b0;
            wb_q       <= 1'b0;
            wbs_q      <= '0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxv_q      <= rx_valid_i;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            off_q      <= off_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            timer_q    <= timer_d;
            tx_en_q    <= tx_en_d;
            tx_guard_q <= tx_en_q;
            tx_data_q  <= tx_data_d;
            sel_q      <= sel_d;
            wb_pend_q  <= wb_pend_d;
            wb_q       <= wb_d;
            wbs_q      <= wbs_d;
            tout_q     <= tout_d;
        end
    end

    assign tx_en_o           = tx_en_q;
    assign tx_data_o         = tx_data_q;
    assign mem_sel_o         = sel_q;
    assign mem_addr_o        = addr_q + ADDR_WIDTH'(off_q);
    assign mem_wdata_o       = sh_q;
    assign mem_we_o          = (state_q == S_WR_MEM);
    assign mem_re_o          = (state_q == S_RD_REQ);
    assign warmboot_o        = wb_q;
    assign warmboot_select_o = wbs_q;
    assign timeout_err_o     = tout_q;
    assign active_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Bench for uart_mem_bridge: UART/memory responders plus a frame-level reference model.
module tb_uart_mem_bridge;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_busy = 1'b0;
    logic        tx_en_o;
    logic [7:0]  tx_data_o;
    logic [3:0]  mem_sel_o;
    logic [13:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        mem_we_o, mem_re_o;
    logic [15:0] mem_rdata = 16'h0000;
    logic        warmboot_o;
    logic [1:0]  warmboot_select_o;
    logic        timeout_err_o, active_o;

    uart_mem_bridge #(.DATA_BYTES(2), .ADDR_WIDTH(14), .SEL_BITS(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_i(reset), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_busy_i(tx_busy), .tx_en_o(tx_en_o), .tx_data_o(tx_data_o),
        .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata),
        .warmboot_o(warmboot_o), .warmboot_select_o(warmboot_select_o),
        .timeout_err_o(timeout_err_o), .active_o(active_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  sel;
        logic [13:0] addr;
        logic [15:0] dat;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          tx_cyc = 0;
    int          last_cyc = 0;
    int          busy_cnt = 0;
    int          re_cnt = 0;
    int          mk;
    logic [7:0]  tx_q[$];
    wr_t         wr_q[$];
    logic [15:0] mem[int];
    logic [15:0] ref_mem[int];
    logic [15:0] pay_q[$];

    function automatic int mkey(logic [3:0] s, logic [13:0] a);
        return int'({s, a});
    endfunction

    function automatic logic [15:0] initval(int k);
        return 16'(k * 40503 + 7);
    endfunction

    always @(posedge clk) cyc++;

    // UART transmitter and memory responders, sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_en_o) begin
            tx_q.push_back(tx_data_o);
            tx_cyc   = cyc;
            busy_cnt = $urandom_range(2, 6);
            tx_busy  = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            tx_busy = (busy_cnt != 0);
        end
        if (mem_we_o) begin
            wr_q.push_back('{sel: mem_sel_o, addr: mem_addr_o, dat: mem_wdata_o});
            mem[mkey(mem_sel_o, mem_addr_o)] = mem_wdata_o;
        end
        if (mem_re_o) begin
            re_cnt++;
            mk = mkey(mem_sel_o, mem_addr_o);
            mem_rdata = mem.exists(mk) ? mem[mk] : initval(mk);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data  = b;
        rx_valid = 1'b1;
        last_cyc = cyc;
        tick(hold);
        rx_valid = 1'b0;
        tick($urandom_range(1, 4));
    endtask

    task automatic wait_done(input int nexp);
        int n;
        n = 0;
        while ((tx_q.size() < nexp || active_o) && n < 4000) begin
            tick(1);
            n++;
        end
        tick(12);
        chk("done_within_budget", 32'(n < 4000), 32'd1);
    endtask

    // Reference: frame-level model of one read/write command.
    task automatic run_rw(input bit wr, input logic [3:0] sel, input logic [13:0] addr,
                          input logic [7:0] len, input string tag);
        logic [7:0]  exp_tx[$];
        wr_t         exp_wr[$];
        logic [7:0]  sum;
        logic [15:0] d;
        int          a, k;
        sum = 8'h00;
        tx_q.delete();
        wr_q.delete();
        re_cnt = 0;
        send_byte({1'b0, wr, 2'b00, sel}, $urandom_range(1, 3));
        send_byte({2'($urandom), addr[13:8]}, $urandom_range(1, 3));
        send_byte(addr[7:0], $urandom_range(1, 3));
        send_byte(len, $urandom_range(1, 3));
        for (int i = 0; i <= int'(len); i++) begin
            a = (int'(addr) + i) % 16384;
            k = mkey(sel, 14'(a));
            if (wr) begin
                d = (pay_q.size() > 0) ? pay_q.pop_front() : 16'($urandom);
                send_byte(d[15:8], $urandom_range(1, 3));
                send_byte(d[7:0], $urandom_range(1, 3));
                exp_wr.push_back('{sel: sel, addr: 14'(a), dat: d});
                ref_mem[k] = d;
            end else begin
                d = ref_mem.exists(k) ? ref_mem[k] : initval(k);
                exp_tx.push_back(d[15:8]);
                exp_tx.push_back(d[7:0]);
            end
            sum = sum + d[15:8] + d[7:0];
        end
        exp_tx.push_back(sum);
        exp_tx.push_back(8'h06);
        wait_done(exp_tx.size());
        chk({tag, "_tx_count"}, tx_q.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i), {24'h0, tx_q[i]}, {24'h0, exp_tx[i]});
        chk({tag, "_we_count"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
            chk($sformatf("%s_we%0d_addr", tag, i), {18'h0, wr_q[i].addr}, {18'h0, exp_wr[i].addr});
            chk($sformatf("%s_we%0d_data", tag, i), {16'h0, wr_q[i].dat}, {16'h0, exp_wr[i].dat});
            chk($sformatf("%s_we%0d_sel", tag, i), {28'h0, wr_q[i].sel}, {28'h0, sel});
        end
        chk({tag, "_re_count"}, re_cnt, wr ? 0 : int'(len) + 1);
        chk({tag, "_mem_sel"}, {28'h0, mem_sel_o}, {28'h0, sel});
        chk({tag, "_timeout_err"}, {31'h0, timeout_err_o}, 32'h0);
    endtask

    initial begin
        int n;
        logic [3:0]  rs;
        logic [13:0] ra;
        logic [7:0]  rl;

        tick(3);
        chk("rst_tx_en", {31'h0, tx_en_o}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
        chk("rst_mem_sel", {28'h0, mem_sel_o}, 32'h0);
        chk("rst_mem_addr", {18'h0, mem_addr_o}, 32'h0);
        chk("rst_mem_wdata", {16'h0, mem_wdata_o}, 32'h0);
        chk("rst_mem_strobes", {30'h0, mem_we_o, mem_re_o}, 32'h0);
        chk("rst_warmboot", {29'h0, warmboot_o, warmboot_select_o}, 32'h0);
        chk("rst_timeout_err", {31'h0, timeout_err_o}, 32'h0);
        chk("rst_active", {31'h0, active_o}, 32'h0);
        reset = 1'b0;
        tick(2);

        // Directed write and read-back of the documented example.
        pay_q = '{16'h1234, 16'hABCD};
        run_rw(1'b1, 4'd3, 14'h0010, 8'd1, "dir_wr");
        chk("dir_wr_sum_literal", {24'h0, tx_q.size() > 0 ? tx_q[0] : 8'h00}, 32'hBE);
        run_rw(1'b0, 4'd3, 14'h0010, 8'd1, "dir_rd");
        chk("dir_rd_first_literal", {24'h0, tx_q.size() > 0 ? tx_q[0] : 8'h00}, 32'h12);

        // Address wrap at the top of the word space.
        run_rw(1'b1, 4'd3, 14'h3FFF, 8'd1, "wrap_wr");
        run_rw(1'b0, 4'd3, 14'h3FFF, 8'd1, "wrap_rd");

        // Randomized write/read-back pairs plus reads of untouched locations.
        for (int t = 0; t < 5; t++) begin
            rs = 4'($urandom);
            ra = (t == 2) ? 14'h3FFD : 14'($urandom);
            rl = 8'($urandom_range(0, 5));
            run_rw(1'b1, rs, ra, rl, $sformatf("rnd%0d_wr", t));
            run_rw(1'b0, rs, ra, rl, $sformatf("rnd%0d_rd", t));
            run_rw(1'b0, 4'($urandom), 14'($urandom), 8'($urandom_range(0, 3)), $sformatf("rnd%0d_rdx", t));
        end

        // CMD byte held high for 50 cycles is one ping.
        tx_q.delete();
        rx_data  = 8'hC0;
        rx_valid = 1'b1;
        tick(50);
        rx_valid = 1'b0;
        wait_done(1);
        chk("held_ping_count", tx_q.size(), 1);
        chk("held_ping_ack", {24'h0, tx_q.size() > 0 ? tx_q[0] : 8'h00}, 32'h06);

        // Inter-byte timeout after one payload byte.
        tx_q.delete();
        wr_q.delete();
        send_byte(8'h41, 1);
        send_byte(8'h00, 1);
        send_byte(8'h20, 1);
        send_byte(8'h00, 1);
        send_byte(8'h77, 1);
        n = 0;
        while (tx_q.size() == 0 && n < 400) begin
            tick(1);
            n++;
        end
        chk("tmo_nak_seen", tx_q.size(), 1);
        chk("tmo_nak_byte", {24'h0, tx_q.size() > 0 ? tx_q[0] : 8'h00}, 32'h15);
        chk("tmo_latency_window", 32'((tx_cyc - last_cyc) >= TO - 5 && (tx_cyc - last_cyc) <= TO + 10), 32'd1);
        chk("tmo_flag", {31'h0, timeout_err_o}, 32'h1);
        chk("tmo_no_write", wr_q.size(), 0);
        tick(10);
        tx_q.delete();
        send_byte(8'hC0, 2);
        wait_done(1);
        chk("tmo_flag_cleared", {31'h0, timeout_err_o}, 32'h0);
        chk("tmo_next_ping", {24'h0, tx_q.size() > 0 ? tx_q[0] : 8'h00}, 32'h06);

        // Warmboot request.
        send_byte(8'h82, 1);
        tick(3);
        chk("wb_select", {30'h0, warmboot_select_o}, 32'h2);
        chk("wb_req", {31'h0, warmboot_o}, 32'h1);
        chk("wb_idle", {31'h0, active_o}, 32'h0);

        // Async reset while waiting on the transmitter.
        tx_q.delete();
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        send_byte(8'h10, 1);
        send_byte(8'h03, 1);
        n = 0;
        while (tx_q.size() == 0 && n < 300) begin
            tick(1);
            n++;
        end
        chk("rst_mid_first_byte", tx_q.size(), 1);
        chk("rst_mid_active_before", {31'h0, active_o}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_tx_en", {31'h0, tx_en_o}, 32'h0);
        chk("rst_mid_active", {31'h0, active_o}, 32'h0);
        chk("rst_mid_warmboot", {31'h0, warmboot_o}, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(10);
        chk("rst_mid_no_nak", tx_q.size(), 1);
        tx_q.delete();
        send_byte(8'hC0, 1);
        wait_done(1);
        chk("rst_ping_count", tx_q.size(), 1);
        chk("rst_ping_ack", {24'h0, tx_q.size() > 0 ? tx_q[0] : 8'h00}, 32'h06);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
